// File: rtl/rtc_counter.sv
// BCD calendar/clock: loadable date/time that advances once per CLK_DIV cycles,
// carrying through month lengths, leap years and the 9999 -> 0000 year wrap.
module rtc_counter #(
    parameter int unsigned CLK_DIV = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        load,
    input  logic [15:0] set_year,
    input  logic [7:0]  set_month,
    input  logic [7:0]  set_day,
    input  logic [7:0]  set_hour,
    input  logic [7:0]  set_minute,
    input  logic [7:0]  set_sec,
    input  logic [3:0]  set_week,
    output logic [15:0] year,
    output logic [7:0]  month,
    output logic [7:0]  day,
    output logic [7:0]  hour,
    output logic [7:0]  minute,
    output logic [7:0]  sec,
    output logic [3:0]  week,
    output logic        sec_pulse
);

    localparam int unsigned    PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [15:0]   r_year;
    logic [7:0]    r_month, r_day, r_hour, r_minute, r_sec;
    logic [3:0]    r_week;
    logic          r_pulse;

    logic          w_tick;
    logic          w_leap;
    logic [7:0]    w_dim;
    logic          w_c_sec, w_c_min, w_c_hour, w_c_day, w_c_month;
    logic [15:0]   w_year_n;
    logic [7:0]    w_month_n, w_day_n, w_hour_n, w_minute_n, w_sec_n;
    logic [3:0]    w_week_n;

    function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
        if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [15:0] bcd4_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (c) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Two BCD digits divisible by 4: even tens with units 0/4/8, odd tens with 2/6.
    function automatic logic bcd_div4(input logic [7:0] b);
        if (!b[4]) return (b[3:0] == 4'd0) || (b[3:0] == 4'd4) || (b[3:0] == 4'd8);
        else       return (b[3:0] == 4'd2) || (b[3:0] == 4'd6);
    endfunction

    assign w_tick = run && (r_presc == PRESC_MAX);
    assign w_leap = (r_year[7:0] != 8'h00) ? bcd_div4(r_year[7:0]) : bcd_div4(r_year[15:8]);

    always_comb begin
        w_dim = 8'h31;
        case (r_month)
            8'h04, 8'h06, 8'h09, 8'h11: w_dim = 8'h30;
            8'h02:                      w_dim = w_leap ? 8'h29 : 8'h28;
            default:                    w_dim = 8'h31;
        endcase
    end

    // Each field carries only when every lower field is at or past its limit.
    always_comb begin
        w_c_sec    = r_sec >= 8'h59;
        w_c_min    = w_c_sec && (r_minute >= 8'h59);
        w_c_hour   = w_c_min && (r_hour >= 8'h23);
        w_c_day    = w_c_hour && (r_day >= w_dim);
        w_c_month  = w_c_day && (r_month >= 8'h12);

        w_sec_n    = w_c_sec ? 8'h00 : bcd2_inc(r_sec);
        w_minute_n = r_minute;
        w_hour_n   = r_hour;
        w_day_n    = r_day;
        w_month_n  = r_month;
        w_year_n   = r_year;
        w_week_n   = r_week;
        if (w_c_sec)   w_minute_n = (r_minute >= 8'h59) ? 8'h00 : bcd2_inc(r_minute);
        if (w_c_min)   w_hour_n   = (r_hour >= 8'h23) ? 8'h00 : bcd2_inc(r_hour);
        if (w_c_hour) begin
            w_day_n  = (r_day >= w_dim) ? 8'h01 : bcd2_inc(r_day);
            w_week_n = (r_week == 4'd6) ? 4'd0 : r_week + 4'd1;
        end
        if (w_c_day)   w_month_n  = (r_month >= 8'h12) ? 8'h01 : bcd2_inc(r_month);
        if (w_c_month) w_year_n   = bcd4_inc(r_year);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc  <= '0;
            r_year   <= 16'h2023;
            r_month  <= 8'h01;
            r_day    <= 8'h01;
            r_hour   <= 8'h00;
            r_minute <= 8'h00;
            r_sec    <= 8'h00;
            r_week   <= 4'd0;
            r_pulse  <= 1'b0;
        end else if (load) begin
            r_presc  <= '0;
            r_year   <= set_year;
            r_month  <= set_month;
            r_day    <= set_day;
            r_hour   <= set_hour;
            r_minute <= set_minute;
            r_sec    <= set_sec;
            r_week   <= set_week;
            r_pulse  <= 1'b0;
        end else begin
            r_pulse <= w_tick;
            if (run) r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_year   <= w_year_n;
                r_month  <= w_month_n;
                r_day    <= w_day_n;
                r_hour   <= w_hour_n;
                r_minute <= w_minute_n;
                r_sec    <= w_sec_n;
                r_week   <= w_week_n;
            end
        end
    end

    assign year      = r_year;
    assign month     = r_month;
    assign day       = r_day;
    assign hour      = r_hour;
    assign minute    = r_minute;
    assign sec       = r_sec;
    assign week      = r_week;
    assign sec_pulse = r_pulse;

endmodule

// File: tb/tb_rtc_counter.sv
// Directed bench for rtc_counter with CLK_DIV=4: tick timing, calendar carries,
// leap rules, load/tick priority, run freeze and mid-run reset.
module tb_rtc_counter;

    logic        clk = 1'b0;
    logic        rst, run, load;
    logic [15:0] set_year;
    logic [7:0]  set_month, set_day, set_hour, set_minute, set_sec;
    logic [3:0]  set_week;
    logic [15:0] year;
    logic [7:0]  month, day, hour, minute, sec;
    logic [3:0]  week;
    logic        sec_pulse;

    int errors = 0;
    int checks = 0;

    rtc_counter #(.CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .run(run), .load(load),
        .set_year(set_year), .set_month(set_month), .set_day(set_day),
        .set_hour(set_hour), .set_minute(set_minute), .set_sec(set_sec),
        .set_week(set_week),
        .year(year), .month(month), .day(day), .hour(hour),
        .minute(minute), .sec(sec), .week(week), .sec_pulse(sec_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_dt(input string tag, input logic [15:0] y, input logic [7:0] mo,
                          input logic [7:0] d, input logic [7:0] h, input logic [7:0] mi,
                          input logic [7:0] s, input logic [3:0] w);
        chk({tag, ".year"},   year,          y);
        chk({tag, ".month"},  {8'h0, month}, {8'h0, mo});
        chk({tag, ".day"},    {8'h0, day},   {8'h0, d});
        chk({tag, ".hour"},   {8'h0, hour},  {8'h0, h});
        chk({tag, ".minute"}, {8'h0, minute},{8'h0, mi});
        chk({tag, ".sec"},    {8'h0, sec},   {8'h0, s});
        chk({tag, ".week"},   {12'h0, week}, {12'h0, w});
    endtask

    // Called at a negedge; returns at the negedge after the load edge.
    task automatic do_load(input logic [15:0] y, input logic [7:0] mo, input logic [7:0] d,
                           input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s,
                           input logic [3:0] w);
        set_year = y; set_month = mo; set_day = d; set_hour = h;
        set_minute = mi; set_sec = s; set_week = w;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic load_tick(input string tag,
                             input logic [15:0] y, input logic [7:0] mo, input logic [7:0] d,
                             input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s,
                             input logic [3:0] w,
                             input logic [15:0] ey, input logic [7:0] emo, input logic [7:0] ed,
                             input logic [7:0] eh, input logic [7:0] emi, input logic [7:0] es,
                             input logic [3:0] ew);
        do_load(y, mo, d, h, mi, s, w);
        chk({tag, ".pulse_after_load"}, {15'h0, sec_pulse}, 16'h0);
        repeat (4) @(negedge clk);
        chk_dt(tag, ey, emo, ed, eh, emi, es, ew);
        chk({tag, ".pulse"}, {15'h0, sec_pulse}, 16'h1);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; load = 1'b0;
        set_year = '0; set_month = '0; set_day = '0; set_hour = '0;
        set_minute = '0; set_sec = '0; set_week = '0;
        repeat (2) @(negedge clk);
        chk_dt("reset", 16'h2023, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 4'd0);
        chk("reset.pulse", {15'h0, sec_pulse}, 16'h0);

        rst = 1'b0; run = 1'b1;
        repeat (3) @(negedge clk);
        chk("first.sec_before", {8'h0, sec}, 16'h00);
        chk("first.pulse_before", {15'h0, sec_pulse}, 16'h0);
        @(negedge clk);
        chk("first.sec", {8'h0, sec}, 16'h01);
        chk("first.pulse", {15'h0, sec_pulse}, 16'h1);
        @(negedge clk);
        chk("first.pulse_drop", {15'h0, sec_pulse}, 16'h0);
        repeat (235) @(negedge clk);
        chk_dt("one_minute", 16'h2023, 8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 4'd0);

        load_tick("newyear",  16'h2023, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 4'd0,
                              16'h2024, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 4'd1);
        load_tick("leap2024", 16'h2024, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 4'd3,
                              16'h2024, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00, 4'd4);
        load_tick("feb29end", 16'h2024, 8'h02, 8'h29, 8'h23, 8'h59, 8'h59, 4'd4,
                              16'h2024, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 4'd5);
        load_tick("nonleap",  16'h2023, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 4'd2,
                              16'h2023, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 4'd3);
        load_tick("cent2100", 16'h2100, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 4'd0,
                              16'h2100, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 4'd1);
        load_tick("cent2000", 16'h2000, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 4'd1,
                              16'h2000, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00, 4'd2);
        load_tick("apr30",    16'h2023, 8'h04, 8'h30, 8'h23, 8'h59, 8'h59, 4'd6,
                              16'h2023, 8'h05, 8'h01, 8'h00, 8'h00, 8'h00, 4'd0);
        load_tick("day09",    16'h2023, 8'h01, 8'h09, 8'h23, 8'h59, 8'h59, 4'd1,
                              16'h2023, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 4'd2);
        load_tick("hour19",   16'h2023, 8'h06, 8'h15, 8'h19, 8'h59, 8'h59, 4'd4,
                              16'h2023, 8'h06, 8'h15, 8'h20, 8'h00, 8'h00, 4'd4);
        load_tick("min39",    16'h2023, 8'h06, 8'h15, 8'h12, 8'h39, 8'h59, 4'd4,
                              16'h2023, 8'h06, 8'h15, 8'h12, 8'h40, 8'h00, 4'd4);
        load_tick("year2019", 16'h2019, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 4'd2,
                              16'h2020, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 4'd3);
        load_tick("sec_oor",  16'h2023, 8'h06, 8'h15, 8'h10, 8'h20, 8'h75, 4'd4,
                              16'h2023, 8'h06, 8'h15, 8'h10, 8'h21, 8'h00, 4'd4);
        load_tick("y9999",    16'h9999, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 4'd3,
                              16'h0000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 4'd4);

        // Prescaler now at 0; three edges put it on the tick cycle.
        repeat (3) @(negedge clk);
        chk("pre_tick.sec", {8'h0, sec}, 16'h00);
        do_load(16'h2023, 8'h07, 8'h04, 8'h08, 8'h30, 8'h10, 4'd2);
        chk_dt("load_on_tick", 16'h2023, 8'h07, 8'h04, 8'h08, 8'h30, 8'h10, 4'd2);
        chk("load_on_tick.pulse", {15'h0, sec_pulse}, 16'h0);

        repeat (2) @(negedge clk);
        run = 1'b0;
        repeat (20) @(negedge clk);
        chk_dt("frozen", 16'h2023, 8'h07, 8'h04, 8'h08, 8'h30, 8'h10, 4'd2);
        chk("frozen.pulse", {15'h0, sec_pulse}, 16'h0);
        run = 1'b1;
        @(negedge clk);
        chk("resume.sec_hold", {8'h0, sec}, 16'h10);
        chk("resume.pulse_hold", {15'h0, sec_pulse}, 16'h0);
        @(negedge clk);
        chk("resume.sec", {8'h0, sec}, 16'h11);
        chk("resume.pulse", {15'h0, sec_pulse}, 16'h1);

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_dt("midrst", 16'h2023, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 4'd0);
        chk("midrst.pulse", {15'h0, sec_pulse}, 16'h0);
        repeat (3) @(negedge clk);
        chk("midrst.sec_hold", {8'h0, sec}, 16'h00);
        @(negedge clk);
        chk("midrst.sec", {8'h0, sec}, 16'h01);
        chk("midrst.pulse_tick", {15'h0, sec_pulse}, 16'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
